uart_tx_arbiter: RTL

//  Shares one UART transmitter (10-bit frame, 9600 baud) among NUM_REQ byte sources, using round-robin order.

---
 rtl/uart_tx_arbiter_pkg.sv | 22 ++
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter_rr_priority_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The serial-line constants describe the transmitter this block feeds.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitAcc,
        StSend,
        StGuard
    } arb_state_e;

    localparam int unsigned CLK_FREQ   = 100_000_000;
    localparam int unsigned BAUD_RATE  = 9600;
    localparam int unsigned FRAME_BITS = 10;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// slave is the arbiter's view; master is the requester/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                      busy;
    logic                      tx_err;

    modport master (
        output req, req_data, tx_busy,
        input  ack, tx_data, tx_start, grant_id, busy, tx_err
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, tx_data, tx_start, grant_id, busy, tx_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning ptr+1, ptr+2, ...
// with wrap at NUM_REQ (which need not be a power of two).
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       valid
);
    localparam int unsigned IDW = $clog2(NUM_REQ);

    int idx;

    // Scan from the farthest offset down so the nearest set bit is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            idx = (int'(ptr) + k) % int'(NUM_REQ);
            if (req[idx]) begin
                winner = IDW'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources:
// grant, latch byte, start, wait for the frame, optional guard gap.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned GUARD_CYCLES = 0
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  =
        cnt_width((BUSY_TIMEOUT > GUARD_CYCLES) ? BUSY_TIMEOUT : GUARD_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);
    localparam logic [CW-1:0] GD_LAST = CW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);

    arb_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic [IDW-1:0]     grant_q, grant_d;
    logic               tx_start_q, tx_start_d;
    logic               tx_err_q, tx_err_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     pick_id;
    logic               pick_valid;

    rr_priority_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .winner(pick_id),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One counter serves both the start-acceptance timeout and the guard gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) state_d = StLaunch;
            end
            StLaunch: begin
                if (!bus.tx_busy) begin
                    state_d = StWaitAcc;
                    cnt_d   = '0;
                end
            end
            StWaitAcc: begin
                if (bus.tx_busy) begin
                    state_d = StSend;
                end else if (cnt_q == TO_LAST) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSend: begin
                if (!bus.tx_busy) begin
                    state_d = (GUARD_CYCLES > 0) ? StGuard : StIdle;
                    cnt_d   = '0;
                end
            end
            StGuard: begin
                if (cnt_q == GD_LAST) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack_d      = '0;
        tx_start_d = 1'b0;
        tx_err_d   = 1'b0;
        busy_d     = (state_d != StIdle);
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    ack_d[pick_id] = 1'b1;
                    tx_data_d      = bus.req_data[pick_id*DATA_W +: DATA_W];
                    grant_d        = pick_id;
                    ptr_d          = pick_id;
                end
            end
            StLaunch:  tx_start_d = !bus.tx_busy;
            StWaitAcc: tx_err_d   = !bus.tx_busy && (cnt_q == TO_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            ptr_q      <= IDW'(NUM_REQ - 1);
            ack_q      <= '0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            tx_start_q <= 1'b0;
            tx_err_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            tx_start_q <= tx_start_d;
            tx_err_q   <= tx_err_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.grant_id = grant_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_err   = tx_err_q;
    assign bus.busy     = busy_q;

endmodule
